// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the MIPS32 multi-cycle controller and the
// datapath muxes it steers.
package mips_ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned COUNT_W  = 32;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Moore decode of controller state into the datapath control vector;
// mem_ready only qualifies the memory wait states.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_ALU;
        end
      end
      // Branch target is computed speculatively here into ALUOut.
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// MIPS32 multi-cycle main controller: state register, next-state logic,
// retired-instruction counter and sticky illegal-opcode flag.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                instr_done,
  output logic                illegal_op,
  output logic [COUNT_W-1:0]  retired_count
);

  state_t               state;
  state_t               state_next;
  ctrl_t                ctrl;
  ctrl_t                ctrl_out;
  logic [COUNT_W-1:0]   count_q;
  logic                 illegal_q;

  // The branch-taken decision is made by the datapath's PC-write gate.
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  mips_ctrl_decode u_decode (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    unique case (state)
      S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BEQ;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_FETCH;
        endcase
      end
      // An opcode that changed away from LW/SW abandons the access.
      S_MEM_ADDR: begin
        if      (opcode == OP_LW) state_next = S_MEM_RD;
        else if (opcode == OP_SW) state_next = S_MEM_WR;
        else                      state_next = S_FETCH;
      end
      S_MEM_RD: state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB: state_next = S_FETCH;
      S_MEM_WR: state_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC: state_next = S_R_WB;
      S_R_WB:   state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                  count_q <= '0;
    else if (ctrl.instr_done) count_q <= count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)                                        illegal_q <= 1'b0;
    else if (state == S_DECODE && !is_legal(opcode)) illegal_q <= 1'b1;
  end

  // Reset forces every output low within the same cycle, before the
  // state register has been cleared.
  assign ctrl_out      = rst ? '0 : ctrl;
  assign illegal_op    = rst ? 1'b0 : illegal_q;
  assign retired_count = rst ? '0 : count_q;

  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign pc_source     = ctrl_out.pc_source;
  assign ir_write      = ctrl_out.ir_write;
  assign i_or_d        = ctrl_out.i_or_d;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign reg_dst       = ctrl_out.reg_dst;
  assign mem_to_reg    = ctrl_out.mem_to_reg;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign instr_done    = ctrl_out.instr_done;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Cycle-by-cycle vector bench for the multi-cycle controller, plus counter
// wrap and CPI sequences.
module tb_mips_multicycle_ctrl;

  // Control vector order: pc_write pc_write_cond pc_source ir_write i_or_d
  // mem_read mem_write reg_dst mem_to_reg reg_write alu_src_a alu_src_b alu_op instr_done
  localparam logic [16:0] C_NONE  = 17'b0;
  localparam logic [16:0] C_FWAIT = 17'b0_0_00_0_0_1_0_0_0_0_0_01_00_0;
  localparam logic [16:0] C_FRDY  = 17'b1_0_00_1_0_1_0_0_0_0_0_01_00_0;
  localparam logic [16:0] C_DEC   = 17'b0_0_00_0_0_0_0_0_0_0_0_11_00_0;
  localparam logic [16:0] C_MA    = 17'b0_0_00_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [16:0] C_MRD   = 17'b0_0_00_0_1_1_0_0_0_0_0_00_00_0;
  localparam logic [16:0] C_MWB   = 17'b0_0_00_0_0_0_0_0_1_1_0_00_00_1;
  localparam logic [16:0] C_MWW   = 17'b0_0_00_0_1_0_1_0_0_0_0_00_00_0;
  localparam logic [16:0] C_MWD   = 17'b0_0_00_0_1_0_1_0_0_0_0_00_00_1;
  localparam logic [16:0] C_REX   = 17'b0_0_00_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [16:0] C_RWB   = 17'b0_0_00_0_0_0_0_1_0_1_0_00_00_1;
  localparam logic [16:0] C_BEQ   = 17'b0_1_01_0_0_0_0_0_0_0_1_00_01_1;
  localparam logic [16:0] C_JMP   = 17'b1_0_10_0_0_0_0_0_0_0_0_00_00_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic        az;
    logic [16:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] retired_count;

  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs[$];

  mips_multicycle_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .alu_zero      (alu_zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] act_ctrl();
    return {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
            mem_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
            alu_op, instr_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic mr, input logic az,
                     input logic [16:0] c, input logic ill, input logic [31:0] cnt);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.az = az; v.ctrl = c; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Drive one cycle at the falling edge, check mid-cycle, advance to next falling edge.
  task automatic step(input vec_t v, input string tag);
    rst = v.rst; opcode = v.op; mem_ready = v.mr; alu_zero = v.az;
    #1;
    check({tag, " ctrl"}, 32'(act_ctrl()), 32'(v.ctrl));
    check({tag, " illegal_op"}, 32'(illegal_op), 32'(v.ill));
    check({tag, " retired_count"}, retired_count, v.cnt);
    @(negedge clk);
  endtask

  task automatic run_cpi(input logic [5:0] op, input int exp_cycles, input string name);
    int n = 0;
    logic done = 1'b0;
    while (!done && n < 20) begin
      rst = 1'b0; opcode = op; mem_ready = 1'b1;
      #1;
      n++;
      done = instr_done;
      @(negedge clk);
    end
    check(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t w;
    //  rst op        mr az ctrl     ill cnt
    add(1, 6'h00,     1, 0, C_NONE,  0, 0);   // reset
    add(0, 6'h3f,     1, 0, C_FRDY,  0, 0);   // R-type
    add(0, 6'b000000, 0, 0, C_DEC,   0, 0);
    add(0, 6'h3f,     0, 0, C_REX,   0, 0);
    add(0, 6'h3f,     0, 0, C_RWB,   0, 0);
    add(0, 6'h00,     1, 0, C_FRDY,  0, 1);   // LW with 2 wait cycles
    add(0, 6'b100011, 1, 0, C_DEC,   0, 1);
    add(0, 6'b100011, 1, 0, C_MA,    0, 1);
    add(0, 6'h00,     0, 0, C_MRD,   0, 1);
    add(0, 6'h00,     0, 0, C_MRD,   0, 1);
    add(0, 6'h00,     1, 0, C_MRD,   0, 1);
    add(0, 6'h00,     0, 0, C_MWB,   0, 1);
    add(0, 6'h00,     0, 0, C_FWAIT, 0, 2);   // SW with fetch and write waits
    add(0, 6'h00,     1, 0, C_FRDY,  0, 2);
    add(0, 6'b101011, 1, 0, C_DEC,   0, 2);
    add(0, 6'b101011, 1, 0, C_MA,    0, 2);
    add(0, 6'h00,     0, 0, C_MWW,   0, 2);
    add(0, 6'h00,     1, 0, C_MWD,   0, 2);
    add(0, 6'h00,     1, 1, C_FRDY,  0, 3);   // BEQ taken
    add(0, 6'b000100, 0, 1, C_DEC,   0, 3);
    add(0, 6'h00,     1, 1, C_BEQ,   0, 3);
    add(0, 6'h00,     1, 0, C_FRDY,  0, 4);   // BEQ not taken
    add(0, 6'b000100, 1, 0, C_DEC,   0, 4);
    add(0, 6'h00,     1, 0, C_BEQ,   0, 4);
    add(0, 6'h00,     1, 0, C_FRDY,  0, 5);   // illegal opcode
    add(0, 6'b111111, 1, 0, C_DEC,   0, 5);
    add(0, 6'h00,     1, 0, C_FRDY,  1, 5);   // J after illegal
    add(0, 6'b000010, 1, 0, C_DEC,   1, 5);
    add(0, 6'h00,     0, 0, C_JMP,   1, 5);
    add(0, 6'h00,     0, 0, C_FWAIT, 1, 6);
    add(0, 6'h00,     1, 0, C_FRDY,  1, 6);   // SW aborted by reset
    add(0, 6'b101011, 1, 0, C_DEC,   1, 6);
    add(0, 6'b101011, 1, 0, C_MA,    1, 6);
    add(0, 6'h00,     0, 0, C_MWW,   1, 6);
    add(1, 6'h00,     1, 0, C_NONE,  0, 0);   // rst with would-be retire
    add(0, 6'h00,     0, 0, C_FWAIT, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Counter wrap: preload all-ones, then retire a J.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    check("wrap preload", retired_count, 32'hFFFF_FFFF);
    w.rst = 0; w.op = 6'h00; w.mr = 1; w.az = 0; w.ill = 0;
    w.ctrl = C_FRDY; w.cnt = 32'hFFFF_FFFF; step(w, "wrap fetch");
    w.op = 6'b000010; w.ctrl = C_DEC;          step(w, "wrap decode");
    w.op = 6'h00;     w.ctrl = C_JMP;          step(w, "wrap jump");
    w.mr = 0; w.ctrl = C_FWAIT; w.cnt = 32'd0; step(w, "wrap result");

    // CPI with mem_ready tied high.
    run_cpi(6'b000000, 4, "cpi rtype");
    run_cpi(6'b100011, 5, "cpi lw");
    run_cpi(6'b101011, 4, "cpi sw");
    run_cpi(6'b000100, 3, "cpi beq");
    run_cpi(6'b000010, 3, "cpi j");
    #1;
    check("count after cpi", retired_count, 32'd5);
    check("illegal after cpi", 32'(illegal_op), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main controller for the MIPS32 core. It replaces single-cycle opcode decode with a Moore state machine that steps the shared datapath (one ALU, one unified memory port, register file) through fetch, decode, execute, memory and write-back. It supports R-type, LW, SW, BEQ and J. It waits on a memory ready handshake, flags illegal opcodes, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register, valid from DECODE onward
- alu_zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write, pc_write_cond  out  1  unconditional PC load; PC load gated by alu_zero
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
- ir_write, i_or_d  out  1  IR load; memory address select (0 PC, 1 ALUOut)
- mem_read, mem_write  out  1  memory strobes, held until mem_ready
- reg_dst, mem_to_reg, reg_write  out  1  write-back controls
- alu_src_a  out  1  0 PC, 1 register A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm << 2
- alu_op  out  2  00 add, 01 sub, 10 decode funct (existing ALU control)
- instr_done  out  1  one-cycle pulse per retired instruction
- illegal_op  out  1  sticky, set on an unsupported opcode
- retired_count  out  32  retired-instruction counter

## Operation
- The state register resets to FETCH. While rst is high, every output is 0, including retired_count and illegal_op.
- Outputs are decoded from the state, plus mem_ready in the wait states. Any control not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00. When mem_ready is high, ir_write=1, pc_write=1, pc_source=00, and the FSM moves to DECODE. Otherwise it stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 → BEQ
  - 000010 → JUMP
  - anything else → FETCH, with illegal_op set
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, i_or_d=1. Goes to MEM_WB when mem_ready is high.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 → FETCH.
- MEM_WR: mem_write=1, i_or_d=1. When mem_ready is high, instr_done=1 and the FSM returns to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 → FETCH.
- retired_count increments on every instr_done and wraps from 0xFFFF_FFFF to 0.
- illegal_op clears only on rst. The illegal instruction is skipped: no instr_done, and the PC has already advanced by 4.
- An unknown state encoding recovers to FETCH.

## Timing
- With mem_ready tied high, CPI is fixed: R=4, LW=5, SW=4, BEQ=3, J=3.
- Each cycle with mem_ready low in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes stay asserted and stable throughout.
- mem_ready is ignored in every other state.
- opcode is sampled only in DECODE and MEM_ADDR. Changes in other states have no effect.
- retired_count shows the increment in the cycle after the instr_done pulse.
- rst asserted mid-instruction (including during a memory wait): on the next edge the state is FETCH, all strobes drop, and no write or retire occurs for the aborted instruction.
- A simultaneous rst and instr_done: rst wins, and the counter reads 0.

## Structure
- Package mips_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - alu_op constants ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_source select constants, reused by the datapath muxes
- One sub-module, mips_ctrl_decode: purely combinational state-to-control-vector decode. The top level holds the state register, next-state logic, counter and sticky flag.

## Test plan
- mem_ready=1, opcode=000000 → states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 with reg_dst=1 in cycle 4; retired_count=1.
- LW (100011) with mem_ready low for 2 cycles in MEM_RD → 7 cycles total; mem_read held high throughout; reg_write with mem_to_reg=1 once.
- BEQ (000100) with alu_zero=1, then with alu_zero=0 → pc_write_cond=1, pc_source=01 in cycle 3 in both cases; 3 cycles each; retired_count=2.
- opcode=111111 → illegal_op=1 after DECODE, back in FETCH, instr_done never pulses; a following J (000010) still retires, and illegal_op stays 1.
- rst asserted during a MEM_WR wait → the next cycle has mem_write=0 and state FETCH; retired_count=0 and illegal_op=0.
- retired_count forced near wrap (0xFFFF_FFFF preload via 2^32 retires in an accelerated sim, or a test hook) → the next retire reads 0.
